// File: rtl/mod0_rr_scheduler.sv
// Round-robin scheduler sharing one mod0 datapath between NREQ requesters:
// it grants one requester, drives its operands to mod0, waits LAT+1 cycles and returns mod0's result.
module mod0_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_vld,
  output logic [NREQ-1:0]          req_rdy,
  input  logic [NREQ-1:0]          req_b,
  input  logic [3*NREQ-1:0]        req_v,
  output logic                     pib1,
  output logic [2:0]               piv2_2,
  input  logic [3:0]               ov1_3,
  input  logic                     pob2,
  output logic                     rsp_vld,
  input  logic                     rsp_rdy,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [3:0]               rsp_v,
  output logic                     rsp_b,
  output logic                     busy
);

  localparam int              IDW      = $clog2(NREQ);
  localparam logic [2:0]      LAT_C    = 3'(LAT);
  localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [IDW-1:0]  last_grant_r;
  logic [IDW-1:0]  id_r;
  logic [2:0]      cnt_r;
  logic            op_b_r;
  logic [2:0]      op_v_r;
  logic            rsp_vld_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [3:0]      rsp_v_r;
  logic            rsp_b_r;
  logic [IDW:0]    pick_s;
  logic            grant_vld_s;
  logic [IDW-1:0]  win_s;
  logic [NREQ-1:0] req_rdy_s;
  logic            busy_s;

  // Returns {found, index}: first valid requester above last, wrapping modulo NREQ
  // (not 2^IDW, so non-power-of-two NREQ never produces a phantom index).
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!res[IDW] && vld[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(req_vld, last_grant_r);
  assign grant_vld_s = pick_s[IDW];
  assign win_s       = pick_s[IDW-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) state_next_s = ST_WAIT;
        else             state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) state_next_s = ST_RESP;
        else               state_next_s = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_rdy) state_next_s = ST_IDLE;
        else         state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode; the accept strobe is combinational so the winner sees it in its request cycle
  always_comb begin
    req_rdy_s = '0;
    busy_s    = (state_r != ST_IDLE);
    if (!rst && (state_r == ST_IDLE) && grant_vld_s) begin
      req_rdy_s[win_s] = 1'b1;
    end else begin
      req_rdy_s = '0;
    end
  end

  // Operand latch, settle counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= LAST_RST;
      id_r         <= '0;
      cnt_r        <= 3'd0;
      op_b_r       <= 1'b0;
      op_v_r       <= 3'd0;
      rsp_vld_r    <= 1'b0;
      rsp_id_r     <= '0;
      rsp_v_r      <= 4'd0;
      rsp_b_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            op_b_r <= req_b[win_s];
            op_v_r <= req_v[32'd3 * 32'(win_s) +: 3];
            id_r   <= win_s;
            cnt_r  <= LAT_C;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 3'd0) begin
            rsp_v_r   <= ov1_3;
            rsp_b_r   <= pob2;
            rsp_id_r  <= id_r;
            rsp_vld_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_vld_r && rsp_rdy) begin
            rsp_vld_r    <= 1'b0;
            last_grant_r <= id_r;
          end
        end
        default: begin
          rsp_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy = req_rdy_s;
  assign busy    = busy_s;
  assign pib1    = op_b_r;
  assign piv2_2  = op_v_r;
  assign rsp_vld = rsp_vld_r;
  assign rsp_id  = rsp_id_r;
  assign rsp_v   = rsp_v_r;
  assign rsp_b   = rsp_b_r;

endmodule

// File: tb/tb_mod0_rr_scheduler.sv
// Directed bench for mod0_rr_scheduler: a LAT=1 instance and a LAT=0 instance,
// each driven against a small behavioural stand-in for mod0.
module tb_mod0_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_vld, req_rdy, req_b;
  logic [11:0] req_v;
  logic        pib1, pob2, rsp_vld, rsp_rdy, rsp_b, busy;
  logic [2:0]  piv2_2;
  logic [3:0]  ov1_3, rsp_v;
  logic [1:0]  rsp_id;

  logic [3:0]  z_req_vld, z_req_rdy, z_req_b;
  logic [11:0] z_req_v;
  logic        z_pib1, z_pob2, z_rsp_vld, z_rsp_rdy, z_rsp_b, z_busy;
  logic [2:0]  z_piv2_2;
  logic [3:0]  z_ov1_3, z_rsp_v;
  logic [1:0]  z_rsp_id;

  int tests = 0;
  int fails = 0;

  // Operand table per requester, shared by both instances
  logic [2:0] tv [4];
  logic       tb_b [4];

  function automatic logic [3:0] m_ov(input logic b, input logic [2:0] v);
    return {v, b} ^ 4'b1010;
  endfunction

  function automatic logic m_pob(input logic b, input logic [2:0] v);
    return ~(^{v, b});
  endfunction

  assign ov1_3   = m_ov(pib1, piv2_2);
  assign pob2    = m_pob(pib1, piv2_2);
  assign z_ov1_3 = m_ov(z_pib1, z_piv2_2);
  assign z_pob2  = m_pob(z_pib1, z_piv2_2);

  mod0_rr_scheduler #(.NREQ(4), .LAT(1)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_b(req_b),
    .req_v(req_v), .pib1(pib1), .piv2_2(piv2_2), .ov1_3(ov1_3), .pob2(pob2),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_v(rsp_v),
    .rsp_b(rsp_b), .busy(busy)
  );

  mod0_rr_scheduler #(.NREQ(4), .LAT(0)) dut_z (
    .clk(clk), .rst(rst), .req_vld(z_req_vld), .req_rdy(z_req_rdy), .req_b(z_req_b),
    .req_v(z_req_v), .pib1(z_pib1), .piv2_2(z_piv2_2), .ov1_3(z_ov1_3), .pob2(z_pob2),
    .rsp_vld(z_rsp_vld), .rsp_rdy(z_rsp_rdy), .rsp_id(z_rsp_id), .rsp_v(z_rsp_v),
    .rsp_b(z_rsp_b), .busy(z_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full LAT=1 transaction with rsp_rdy held high; entered in the accept cycle, leaves in the next IDLE cycle
  task automatic transact(input int g);
    #1;
    check($sformatf("rr_rdy_g%0d", g), 32'(req_rdy), 32'(4'b0001 << g));
    tick();
    check($sformatf("rr_piv_g%0d", g), 32'(piv2_2), 32'(tv[g]));
    check($sformatf("rr_pib_g%0d", g), 32'(pib1), 32'(tb_b[g]));
    check($sformatf("rr_gap_g%0d", g), 32'(req_rdy), 32'd0);
    tick();
    check($sformatf("rr_early_g%0d", g), 32'(rsp_vld), 32'd0);
    tick();
    check($sformatf("rr_vld_g%0d", g), 32'(rsp_vld), 32'd1);
    check($sformatf("rr_id_g%0d", g), 32'(rsp_id), 32'(g));
    check($sformatf("rr_v_g%0d", g), 32'(rsp_v), 32'(m_ov(tb_b[g], tv[g])));
    check($sformatf("rr_b_g%0d", g), 32'(rsp_b), 32'(m_pob(tb_b[g], tv[g])));
    tick();
  endtask

  initial begin
    tv[0] = 3'b100; tv[1] = 3'b001; tv[2] = 3'b110; tv[3] = 3'b011;
    tb_b[0] = 1'b0; tb_b[1] = 1'b1; tb_b[2] = 1'b0; tb_b[3] = 1'b1;

    rst = 1'b1;
    req_vld = 4'd0; req_b = 4'd0; req_v = 12'd0; rsp_rdy = 1'b0;
    z_req_vld = 4'd0; z_req_b = 4'b1010; z_req_v = 12'b011_110_001_100; z_rsp_rdy = 1'b1;
    tick();
    tick();
    check("rst_rdy", 32'(req_rdy), 32'd0);
    check("rst_pib", 32'(pib1), 32'd0);
    check("rst_piv", 32'(piv2_2), 32'd0);
    check("rst_rspvld", 32'(rsp_vld), 32'd0);
    check("rst_rspid", 32'(rsp_id), 32'd0);
    check("rst_rspv", 32'(rsp_v), 32'd0);
    check("rst_rspb", 32'(rsp_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 2
    req_vld = 4'b0100; req_v = 12'b000_101_000_000; req_b = 4'b0100;
    #1;
    check("t1_rdy", 32'(req_rdy), 32'b0100);
    tick();
    req_vld = 4'd0;
    check("t1_pib", 32'(pib1), 32'd1);
    check("t1_piv", 32'(piv2_2), 32'b101);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_vld_t2", 32'(rsp_vld), 32'd0);
    tick();
    check("t1_vld_t3", 32'(rsp_vld), 32'd1);
    check("t1_id", 32'(rsp_id), 32'd2);
    check("t1_v", 32'(rsp_v), 32'b0001);
    check("t1_b", 32'(rsp_b), 32'd0);
    rsp_rdy = 1'b1;
    tick();
    check("t1_done", 32'(rsp_vld), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_piv_hold", 32'(piv2_2), 32'b101);

    // Round-robin from fresh reset, everyone requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_v = 12'b011_110_001_100; req_b = 4'b1010; req_vld = 4'b1111;
    for (int i = 0; i < 6; i++) transact(i % 4);

    // Wrap: last grant is 1, so 3 then 0 then 3
    req_vld = 4'b1001;
    transact(3);
    transact(0);
    transact(3);

    // Backpressure on requester 2 with others pending
    req_vld = 4'b0100; rsp_rdy = 1'b0;
    #1;
    check("bp_rdy", 32'(req_rdy), 32'b0100);
    tick();
    req_vld = 4'b1111;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_vld_%0d", i), 32'(rsp_vld), 32'd1);
      check($sformatf("bp_id_%0d", i), 32'(rsp_id), 32'd2);
      check($sformatf("bp_v_%0d", i), 32'(rsp_v), 32'(m_ov(tb_b[2], tv[2])));
      check($sformatf("bp_b_%0d", i), 32'(rsp_b), 32'(m_pob(tb_b[2], tv[2])));
      check($sformatf("bp_rdy_%0d", i), 32'(req_rdy), 32'd0);
      check($sformatf("bp_busy_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    rsp_rdy = 1'b1;
    #1;
    check("bp_hs_vld", 32'(rsp_vld), 32'd1);
    check("bp_hs_rdy", 32'(req_rdy), 32'd0);
    tick();
    check("bp_after_vld", 32'(rsp_vld), 32'd0);
    check("bp_after_busy", 32'(busy), 32'd0);
    check("bp_after_rdy", 32'(req_rdy), 32'b1000);
    req_vld = 4'd0;
    tick();
    check("bp_idle", 32'(busy), 32'd0);

    // Reset in the middle of WAIT for requester 1
    req_vld = 4'b0010;
    #1;
    check("rw_rdy", 32'(req_rdy), 32'b0010);
    tick();
    req_vld = 4'b1111;
    check("rw_piv", 32'(piv2_2), 32'b001);
    rst = 1'b1;
    #1;
    check("rw_rdy0", 32'(req_rdy), 32'd0);
    check("rw_pib0", 32'(pib1), 32'd0);
    check("rw_piv0", 32'(piv2_2), 32'd0);
    check("rw_vld0", 32'(rsp_vld), 32'd0);
    check("rw_busy0", 32'(busy), 32'd0);
    check("rw_rspv0", 32'(rsp_v), 32'd0);
    req_vld = 4'd0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rw_novld_%0d", i), 32'(rsp_vld), 32'd0);
    end
    req_vld = 4'b1111;
    transact(0);
    req_vld = 4'd0;

    // LAT=0 instance: response two cycles after accept, three-cycle period
    z_req_vld = 4'b0001;
    #1;
    check("z_rdy_t0", 32'(z_req_rdy), 32'b0001);
    tick();
    check("z_vld_t1", 32'(z_rsp_vld), 32'd0);
    check("z_rdy_t1", 32'(z_req_rdy), 32'd0);
    tick();
    check("z_vld_t2", 32'(z_rsp_vld), 32'd1);
    check("z_id_t2", 32'(z_rsp_id), 32'd0);
    check("z_v_t2", 32'(z_rsp_v), 32'(m_ov(tb_b[0], tv[0])));
    check("z_b_t2", 32'(z_rsp_b), 32'(m_pob(tb_b[0], tv[0])));
    tick();
    check("z_rdy_t3", 32'(z_req_rdy), 32'b0001);
    tick();
    tick();
    check("z_vld_t5", 32'(z_rsp_vld), 32'd1);
    tick();
    check("z_rdy_t6", 32'(z_req_rdy), 32'b0001);
    z_req_vld = 4'd0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
